image_receiver: RTL and testbench

Receiving end of the camera-image UART link. Deserialises the 8N1 byte stream produced by the pixel transmitter, reassembles 12-bit pixels from byte pairs, and issues one write per pixel into a frame buffer at sequential addresses. Sits between the external UART RX pin and a 320x240x12 dual-port RAM on the display/processing side; `image_ready` flags a complete frame.

---
 rtl/image_link_pkg.sv | 24 ++
 rtl/uart_rx_byte.sv | 88 ++++++++
 rtl/image_receiver.sv | 122 ++++++++++++
 tb/tb_image_receiver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/image_link_pkg.sv
// Shared definitions for the camera-image UART link.
// Covers the pixel/address widths, the wire format and the FSM state encodings.
package image_link_pkg;

    localparam int PIXEL_W      = 12;
    localparam int ADDR_W       = 17;
    localparam int FRAME_PIXELS = 320 * 240;

    // byte0 of every pixel carries this value in its upper nibble
    localparam logic [3:0] HDR_NIBBLE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic {
        HI,
        LO
    } asm_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser.
// It produces a one-cycle byte_valid pulse, or a stop_err pulse when the stop bit is bad.
module uart_rx_byte
    import image_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LIMIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LIMIT  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync_meta;
    logic             line;
    logic             line_prev;
    rx_state_t        state;
    rx_state_t        next_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_meta <= uart_in;
            line      <= sync_meta;
            line_prev <= line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // After a bad stop bit the line may still be low. IDLE only leaves on a falling
    // edge, so the FSM waits there until the line has gone high again.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (line_prev && !line) next_state = START;
            START:   if (tick) next_state = line ? IDLE : DATA;
            DATA:    if (tick && bit_idx == 3'd7) next_state = STOP;
            STOP:    if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tick = 1'b0;
        case (state)
            IDLE:    tick = 1'b0;
            START:   tick = (clk_cnt == HALF_LIMIT);
            default: tick = (clk_cnt == BIT_LIMIT);
        endcase
        byte_valid = (state == STOP) && tick && line;
        stop_err   = (state == STOP) && tick && !line;
        rx_byte    = shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            clk_cnt <= (state == IDLE || tick) ? '0 : clk_cnt + 1'b1;
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (tick) begin
                shift   <= {line, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_receiver.sv
// Image receiver: turns UART byte pairs into 12-bit pixels written to sequential frame-buffer addresses.
// Defining IMAGE_RX_TIMEOUT_EN adds an idle-gap watchdog that resynchronises partial frames.
module image_receiver
    import image_link_pkg::*;
#(
    parameter int NUM_PIXELS   = FRAME_PIXELS,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_in,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  address,
    output logic [PIXEL_W-1:0] pixel,
    output logic               image_ready,
    output logic               frame_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_PIXELS);

    logic             byte_valid;
    logic             stop_err;
    logic [7:0]       rx_byte;
    asm_state_t       state;
    asm_state_t       next_state;
    logic [3:0]       nibble;
    logic [CNT_W-1:0] count;
    logic             header_ok;
    logic             hdr_err;
    logic             do_write;
    logic             timeout_hit;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .stop_err   (stop_err)
    );

`ifdef IMAGE_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CLKS);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst || byte_valid)          idle_cnt <= '0;
        else if (idle_cnt != IDLE_LIMIT) idle_cnt <= idle_cnt + 1'b1;
    end

    // A finished frame is left alone; only a partially received frame is abandoned.
    assign timeout_hit = !byte_valid && (idle_cnt == IDLE_LIMIT) && !image_ready
                         && (state == LO || count != '0);
`else
    // Constant 0: this build has no idle watchdog.
    assign timeout_hit = (TIMEOUT_CLKS < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= HI;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (byte_valid) begin
            case (state)
                HI:      if (header_ok) next_state = LO;
                LO:      next_state = HI;
                default: next_state = HI;
            endcase
        end else if (timeout_hit) begin
            next_state = HI;
        end
    end

    always_comb begin
        header_ok = (rx_byte[7:4] == HDR_NIBBLE);
        hdr_err   = byte_valid && (state == HI) && !header_ok;
        do_write  = byte_valid && (state == LO);
    end

    // The first valid byte after a completed frame restarts the count and is then handled as byte0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en       <= 1'b0;
            address     <= '0;
            pixel       <= '0;
            image_ready <= 1'b0;
            frame_err   <= 1'b0;
            nibble      <= '0;
            count       <= '0;
        end else begin
            wr_en     <= do_write;
            frame_err <= stop_err || hdr_err;
            if (byte_valid) begin
                if (state == HI && header_ok) nibble <= rx_byte[3:0];
                if (do_write) begin
                    pixel       <= {nibble, rx_byte};
                    address     <= count[ADDR_W-1:0];
                    count       <= count + 1'b1;
                    image_ready <= (count == FULL_COUNT - 1'b1);
                end else if (image_ready) begin
                    count       <= '0;
                    image_ready <= 1'b0;
                end
            end else if (timeout_hit) begin
                count  <= '0;
                nibble <= '0;
            end
        end
    end

endmodule

// File: tb/tb_image_receiver.sv
// Self-checking bench for image_receiver: a UART byte driver plus a write scoreboard.
// Build both bench and RTL with IMAGE_RX_TIMEOUT_EN to include the idle-gap resync scenario.
`timescale 1ns/1ps
module tb_image_receiver;

    localparam int CPB  = 8;
    localparam int NPIX = 4;
    localparam int TMO  = 160;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_in = 1'b1;
    logic        wr_en;
    logic [16:0] address;
    logic [11:0] pixel;
    logic        image_ready;
    logic        frame_err;

    typedef struct packed {
        logic [16:0] addr;
        logic [11:0] pix;
    } wr_t;

    wr_t expected_q[$];
    wr_t exp_wr;
    int  checks = 0;
    int  errors = 0;
    int  fe_count = 0;
    int  bv_count = 0;
    int  wr_count = 0;
    int  fe_base;
    int  bv_base;
    int  wr_base;

    image_receiver #(
        .NUM_PIXELS   (NPIX),
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .wr_en       (wr_en),
        .address     (address),
        .pixel       (pixel),
        .image_ready (image_ready),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        uart_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stop_bit);
        driveBit(1'b1);
        driveBit(1'b1);
    endtask

    task automatic expectWrite(input logic [16:0] addr, input logic [11:0] pix);
        wr_t w;
        w.addr = addr;
        w.pix  = pix;
        expected_q.push_back(w);
    endtask

    task automatic sendPixel(input logic [11:0] pix, input logic [16:0] addr);
        expectWrite(addr, pix);
        applyStimulus({4'h0, pix[11:8]}, 1'b1);
        applyStimulus(pix[7:0], 1'b1);
    endtask

    task automatic settle(input string tag);
        repeat (20) @(negedge clk);
        checkOutput(tag, 32'(expected_q.size()), 32'd0);
    endtask

    task automatic doReset();
        expected_q.delete();
        uart_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_count++;
            checkOutput("write_pending", 32'(expected_q.size() > 0), 32'd1);
            if (expected_q.size() > 0) begin
                exp_wr = expected_q.pop_front();
                checkOutput("wr_address", 32'(address), 32'(exp_wr.addr));
                checkOutput("wr_pixel", 32'(pixel), 32'(exp_wr.pix));
            end
        end
        if (frame_err) fe_count++;
        if (dut.u_rx.byte_valid) bv_count++;
    end

    initial begin
        repeat (4) @(negedge clk);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_address", 32'(address), 32'd0);
        checkOutput("rst_pixel", 32'(pixel), 32'd0);
        checkOutput("rst_image_ready", 32'(image_ready), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] full frame");
        wr_base = wr_count;
        sendPixel(12'hABC, 17'd0);
        sendPixel(12'h123, 17'd1);
        sendPixel(12'hFFF, 17'd2);
        checkOutput("ready_early", 32'(image_ready), 32'd0);
        sendPixel(12'h000, 17'd3);
        settle("frame_pending");
        checkOutput("frame_ready", 32'(image_ready), 32'd1);
        checkOutput("frame_writes", 32'(wr_count - wr_base), 32'd4);

        $display("[TB] bad stop bit");
        fe_base = fe_count;
        wr_base = wr_count;
        applyStimulus(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("stop_err_pulse", 32'(fe_count - fe_base), 32'd1);
        checkOutput("stop_err_nowrite", 32'(wr_count - wr_base), 32'd0);
        checkOutput("ready_held", 32'(image_ready), 32'd1);
        expectWrite(17'd0, 12'h345);
        applyStimulus(8'h03, 1'b1);
        checkOutput("ready_cleared", 32'(image_ready), 32'd0);
        applyStimulus(8'h45, 1'b1);
        settle("after_stop_pending");
        checkOutput("stop_err_single", 32'(fe_count - fe_base), 32'd1);

        $display("[TB] stray header byte");
        doReset();
        fe_base = fe_count;
        applyStimulus(8'hF3, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("hdr_err_pulse", 32'(fe_count - fe_base), 32'd1);
        sendPixel(12'h789, 17'd0);
        settle("hdr_pending");
        checkOutput("hdr_err_single", 32'(fe_count - fe_base), 32'd1);

        $display("[TB] idle glitch");
        doReset();
        fe_base = fe_count;
        bv_base = bv_count;
        uart_in = 1'b0;
        @(negedge clk);
        uart_in = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_byte", 32'(bv_count - bv_base), 32'd0);
        checkOutput("glitch_no_err", 32'(fe_count - fe_base), 32'd0);
        sendPixel(12'h456, 17'd0);
        settle("glitch_pending");

`ifdef IMAGE_RX_TIMEOUT_EN
        $display("[TB] idle timeout resync");
        doReset();
        fe_base = fe_count;
        wr_base = wr_count;
        expectWrite(17'd0, 12'h123);
        applyStimulus(8'h0A, 1'b1);
        repeat (200) @(negedge clk);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h23, 1'b1);
        settle("timeout_pending");
        checkOutput("timeout_writes", 32'(wr_count - wr_base), 32'd1);
        checkOutput("timeout_no_err", 32'(fe_count - fe_base), 32'd0);
`endif

        $display("[TB] reset mid-byte");
        doReset();
        sendPixel(12'h111, 17'd0);
        sendPixel(12'h222, 17'd1);
        settle("pre_reset_pending");
        bv_base = bv_count;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b1);
        doReset();
        repeat (30) @(negedge clk);
        checkOutput("midbyte_lost", 32'(bv_count - bv_base), 32'd0);
        checkOutput("midbyte_address", 32'(address), 32'd0);
        sendPixel(12'h0F0, 17'd0);
        sendPixel(12'hE1D, 17'd1);
        sendPixel(12'h5A5, 17'd2);
        checkOutput("midbyte_ready_early", 32'(image_ready), 32'd0);
        sendPixel(12'h3C3, 17'd3);
        settle("midbyte_pending");
        checkOutput("midbyte_ready", 32'(image_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
